// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator
// Parses a raw MIDI byte stream for one channel and maps note-on/note-off
// events onto NUM_VOICES voice slots. A new note-on takes the voice already
// playing that note, else a free voice, else it steals the oldest voice.
module midi_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int CHANNEL    = 0,
    parameter int AGE_BITS   = 4,
    parameter int IDX_BITS   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                midi_data,
    input  logic                      midi_valid,
    output logic                      midi_ready,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [7*NUM_VOICES-1:0]   voice_note,
    output logic [7*NUM_VOICES-1:0]   voice_velocity,
    output logic                      voice_update,
    output logic [IDX_BITS-1:0]       voice_update_idx,
    output logic                      voice_stolen
);

    localparam logic [7:0]          NOTE_OFF_STATUS = 8'h80 | 8'(CHANNEL);
    localparam logic [7:0]          NOTE_ON_STATUS  = 8'h90 | 8'(CHANNEL);
    localparam logic [AGE_BITS-1:0] AGE_MAX         = '1;

    // IDLE: no running status, data bytes dropped. EXEC: one cycle in which
    // the latched note/velocity are applied to the voice bank.
    typedef enum logic [1:0] {
        S_IDLE,
        S_NOTE,
        S_VEL,
        S_EXEC
    } state_t;

    state_t state_q, state_d;
    logic   rs_on_q, rs_on_d;          // running status is note-on (1) or note-off (0)
    logic [6:0] note_lat_q, note_lat_d;
    logic [6:0] vel_lat_q, vel_lat_d;

    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [6:0]            note_q [NUM_VOICES];
    logic [6:0]            note_d [NUM_VOICES];
    logic [6:0]            vel_q  [NUM_VOICES];
    logic [6:0]            vel_d  [NUM_VOICES];
    logic [AGE_BITS-1:0]   age_q  [NUM_VOICES];
    logic [AGE_BITS-1:0]   age_d  [NUM_VOICES];

    logic                upd_q, upd_d;
    logic [IDX_BITS-1:0] upd_idx_q, upd_idx_d;
    logic                stolen_q, stolen_d;

    logic                accept;
    logic                match_found, free_found, steal;
    logic [IDX_BITS-1:0] match_idx, free_idx, old_idx, sel_idx;
    logic [AGE_BITS-1:0] old_age;

    assign midi_ready = (state_q != S_EXEC);
    assign accept     = midi_valid && midi_ready;

    // Parser: realtime bytes pass through untouched, channel note status
    // (re)arms running status, any other status drops it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
        state_d    = state_q;
        rs_on_d    = rs_on_q;
        note_lat_d = note_lat_q;
        vel_lat_d  = vel_lat_q;
        if (state_q == S_EXEC) begin
            state_d = S_NOTE;
        end else if (accept && (midi_data < 8'hF8)) begin
            if ((midi_data == NOTE_ON_STATUS) || (midi_data == NOTE_OFF_STATUS)) begin
                rs_on_d = midi_data[4];
                state_d = S_NOTE;
            end else if (midi_data[7]) begin
                rs_on_d = 1'b0;
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_NOTE: begin
                        note_lat_d = midi_data[6:0];
                        state_d    = S_VEL;
                    end
                    S_VEL: begin
                        vel_lat_d = midi_data[6:0];
                        state_d   = S_EXEC;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Voice search: lowest active voice on the latched note, lowest free
    // voice, and oldest voice (first maximum wins ties).
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        old_idx     = '0;
        old_age     = age_q[0];
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate_q[i] && (note_q[i] == note_lat_q) && !match_found) begin
                match_found = 1'b1;
                match_idx   = IDX_BITS'(i);
            end
            if (!gate_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_BITS'(i);
            end
            if (age_q[i] > old_age) begin
                old_age = age_q[i];
                old_idx = IDX_BITS'(i);
            end
        end
        steal   = !match_found && !free_found;
        sel_idx = match_found ? match_idx : (free_found ? free_idx : old_idx);
    end

    // Voice bank update during EXEC; update/stolen are single-cycle pulses.
    always_comb begin
        gate_d    = gate_q;
        note_d    = note_q;
        vel_d     = vel_q;
        age_d     = age_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        stolen_d  = 1'b0;
        if (state_q == S_EXEC) begin
            if (rs_on_q && (vel_lat_q != 7'd0)) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (gate_q[i] && (IDX_BITS'(i) != sel_idx) && (age_q[i] != AGE_MAX)) begin
                        age_d[i] = age_q[i] + AGE_BITS'(1);
                    end
                end
                gate_d[sel_idx] = 1'b1;
                note_d[sel_idx] = note_lat_q;
                vel_d[sel_idx]  = vel_lat_q;
                age_d[sel_idx]  = '0;
                upd_d           = 1'b1;
                upd_idx_d       = sel_idx;
                stolen_d        = steal;
            end else if (match_found) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (gate_q[i] && (note_q[i] == note_lat_q)) begin
                        gate_d[i] = 1'b0;
                    end
                end
                upd_d     = 1'b1;
                upd_idx_d = match_idx;
            end
        end
    end

    // State and voice registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rs_on_q    <= 1'b0;
            note_lat_q <= '0;
            vel_lat_q  <= '0;
            gate_q     <= '0;
            upd_q      <= 1'b0;
            upd_idx_q  <= '0;
            stolen_q   <= 1'b0;
            // NOTE: the per-voice arrays are reset too; they are a few flops each and their reset value is visible on the outputs.
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            rs_on_q    <= rs_on_d;
            note_lat_q <= note_lat_d;
            vel_lat_q  <= vel_lat_d;
            gate_q     <= gate_d;
            upd_q      <= upd_d;
            upd_idx_q  <= upd_idx_d;
            stolen_q   <= stolen_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= note_d[i];
                vel_q[i]  <= vel_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

    // Pack per-voice note/velocity onto the flat output buses.
    always_comb begin
        voice_note     = '0;
        voice_velocity = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[7*i +: 7]     = note_q[i];
            voice_velocity[7*i +: 7] = vel_q[i];
        end
    end

    assign voice_gate       = gate_q;
    assign voice_update     = upd_q;
    assign voice_update_idx = upd_idx_q;
    assign voice_stolen     = stolen_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Testbench for midi_voice_allocator: directed scenarios plus a random byte
// stream, all checked against a behavioural model of the parser and voices.
module tb_midi_voice_allocator;

    localparam int NV = 4;
    localparam int CH = 0;
    localparam int AB = 4;
    localparam int IB = 2;
    localparam int AGE_SAT = (1 << AB) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      midi_data;
    logic            midi_valid;
    logic            midi_ready;
    logic [NV-1:0]   voice_gate;
    logic [7*NV-1:0] voice_note;
    logic [7*NV-1:0] voice_velocity;
    logic            voice_update;
    logic [IB-1:0]   voice_update_idx;
    logic            voice_stolen;

    midi_voice_allocator #(.NUM_VOICES(NV), .CHANNEL(CH), .AGE_BITS(AB)) dut (
        .clk              (clk),
        .rst              (rst),
        .midi_data        (midi_data),
        .midi_valid       (midi_valid),
        .midi_ready       (midi_ready),
        .voice_gate       (voice_gate),
        .voice_note       (voice_note),
        .voice_velocity   (voice_velocity),
        .voice_update     (voice_update),
        .voice_update_idx (voice_update_idx),
        .voice_stolen     (voice_stolen)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model: m_rs = -1 none, 0 note-off, 1 note-on;
    // m_phase = 0 dropping data, 1 expecting note, 2 expecting velocity.
    int m_rs, m_phase, m_note, m_vel;
    int m_gate [NV];
    int m_vnote[NV];
    int m_vvel [NV];
    int m_age  [NV];

    // DUT values captured at the most recent velocity-driven update slot.
    logic          last_upd;
    logic [IB-1:0] last_idx;
    logic          last_stolen;

    task automatic m_reset();
        m_rs = -1; m_phase = 0; m_note = 0; m_vel = 0;
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0; m_vnote[i] = 0; m_vvel[i] = 0; m_age[i] = 0;
        end
    endtask

    // Returns 1 when the byte completes a note message.
    function automatic bit m_byte(input logic [7:0] b);
        int v = int'(b);
        if (v >= 'hF8) return 1'b0;
        if (v == ('h80 | CH)) begin m_rs = 0; m_phase = 1; return 1'b0; end
        if (v == ('h90 | CH)) begin m_rs = 1; m_phase = 1; return 1'b0; end
        if (v >= 'h80) begin m_rs = -1; m_phase = 0; return 1'b0; end
        if (m_phase == 1) begin m_note = v; m_phase = 2; return 1'b0; end
        if (m_phase == 2) begin m_vel = v; m_phase = 1; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic m_exec(output int upd, output int idx, output int st);
        int sel = -1;
        upd = 0; idx = 0; st = 0;
        if (m_rs == 1 && m_vel != 0) begin
            for (int i = 0; i < NV; i++)
                if (sel < 0 && m_gate[i] != 0 && m_vnote[i] == m_note) sel = i;
            for (int i = 0; i < NV; i++)
                if (sel < 0 && m_gate[i] == 0) sel = i;
            if (sel < 0) begin
                st = 1; sel = 0;
                for (int i = 1; i < NV; i++)
                    if (m_age[i] > m_age[sel]) sel = i;
            end
            for (int i = 0; i < NV; i++)
                if (i != sel && m_gate[i] != 0 && m_age[i] < AGE_SAT) m_age[i]++;
            m_gate[sel] = 1; m_vnote[sel] = m_note; m_vvel[sel] = m_vel; m_age[sel] = 0;
            upd = 1; idx = sel;
        end else begin
            for (int i = NV - 1; i >= 0; i--)
                if (m_gate[i] != 0 && m_vnote[i] == m_note) begin
                    m_gate[i] = 0; upd = 1; idx = i;
                end
        end
    endtask

    function automatic logic [7*NV-1:0] m_pack(input bit vel);
        logic [7*NV-1:0] r = '0;
        for (int i = 0; i < NV; i++) r[7*i +: 7] = vel ? 7'(m_vvel[i]) : 7'(m_vnote[i]);
        return r;
    endfunction

    function automatic logic [NV-1:0] m_gates();
        logic [NV-1:0] r = '0;
        for (int i = 0; i < NV; i++) r[i] = (m_gate[i] != 0);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; midi_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    // Wait (bounded) until the presented byte is taken on a rising edge.
    task automatic wait_accept(input logic [7:0] b);
        bit r;
        bit ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); r = midi_ready;
            @(posedge clk); #1;
            if (r) begin ok = 1'b1; break; end
        end
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: byte %h not taken, midi_ready=%b expected 1", b, midi_ready);
        end
    endtask

    // Send one byte and check the DUT against the model after it is taken.
    task automatic send_byte(input logic [7:0] b);
        int e_upd, e_idx, e_st;
        midi_data = b; midi_valid = 1'b1;
        wait_accept(b);
        midi_valid = 1'b0;
        if (m_byte(b)) begin
            vectors++;
            if (midi_ready !== 1'b0) begin
                errors++; $display("FAIL exec_ready: got %b expected 0 (byte %h)", midi_ready, b);
            end
            vectors++;
            if (voice_update !== 1'b0) begin
                errors++; $display("FAIL early_update: got %b expected 0 (byte %h)", voice_update, b);
            end
            @(posedge clk); #1;
            m_exec(e_upd, e_idx, e_st);
            last_upd = voice_update; last_idx = voice_update_idx; last_stolen = voice_stolen;
            vectors++;
            if (voice_update !== 1'(e_upd)) begin
                errors++; $display("FAIL update_pulse: got %b expected %0d (note %h)", voice_update, e_upd, m_note);
            end
            if (e_upd != 0) begin
                vectors++;
                if (voice_update_idx !== IB'(e_idx)) begin
                    errors++; $display("FAIL update_idx: got %0d expected %0d", voice_update_idx, e_idx);
                end
            end
            vectors++;
            if (voice_stolen !== 1'(e_st)) begin
                errors++; $display("FAIL stolen: got %b expected %0d", voice_stolen, e_st);
            end
            @(posedge clk); #1;
            vectors++;
            if (voice_update !== 1'b0 || voice_stolen !== 1'b0) begin
                errors++; $display("FAIL pulse_clear: update=%b stolen=%b expected 0 0", voice_update, voice_stolen);
            end
        end else begin
            vectors++;
            if (voice_update !== 1'b0) begin
                errors++; $display("FAIL spurious_update: got %b expected 0 (byte %h)", voice_update, b);
            end
        end
        vectors++;
        if (voice_gate !== m_gates() || voice_note !== m_pack(1'b0) || voice_velocity !== m_pack(1'b1)) begin
            errors++;
            $display("FAIL voices: gate=%b note=%h vel=%h expected gate=%b note=%h vel=%h",
                     voice_gate, voice_note, voice_velocity, m_gates(), m_pack(1'b0), m_pack(1'b1));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; midi_valid = 1'b0; midi_data = 8'h00;
        m_reset();
        #12;
        vectors++;
        if (voice_gate !== '0 || voice_note !== '0 || voice_velocity !== '0) begin
            errors++; $display("FAIL reset_voices: gate=%b note=%h vel=%h expected all 0", voice_gate, voice_note, voice_velocity);
        end
        vectors++;
        if (midi_ready !== 1'b1 || voice_update !== 1'b0 || voice_stolen !== 1'b0 || voice_update_idx !== '0) begin
            errors++; $display("FAIL reset_ctrl: ready=%b upd=%b st=%b idx=%0d expected 1 0 0 0",
                               midi_ready, voice_update, voice_stolen, voice_update_idx);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_note_on();
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        vectors++;
        if (voice_gate[0] !== 1'b1 || voice_note[6:0] !== 7'h3C || voice_velocity[6:0] !== 7'h64 || last_idx !== 2'd0) begin
            errors++; $display("FAIL note_on: gate0=%b note0=%h vel0=%h idx=%0d expected 1 3c 64 0",
                               voice_gate[0], voice_note[6:0], voice_velocity[6:0], last_idx);
        end
    endtask

    task automatic test_running_status();
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h40); send_byte(8'h50);
        vectors++;
        if (voice_note[13:7] !== 7'h40 || voice_velocity[13:7] !== 7'h50 || voice_gate !== 4'b0011) begin
            errors++; $display("FAIL running_status: note1=%h vel1=%h gate=%b expected 40 50 0011",
                               voice_note[13:7], voice_velocity[13:7], voice_gate);
        end
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
        vectors++;
        if (voice_gate !== 4'b0010 || voice_note[6:0] !== 7'h3C) begin
            errors++; $display("FAIL note_off: gate=%b note0=%h expected 0010 3c", voice_gate, voice_note[6:0]);
        end
    endtask

    task automatic test_steal();
        do_reset();
        send_byte(8'h90);
        for (int n = 'h30; n <= 'h34; n++) begin
            send_byte(8'(n)); send_byte(8'h64);
        end
        vectors++;
        if (last_stolen !== 1'b1 || last_idx !== 2'd0 || voice_note[6:0] !== 7'h34) begin
            errors++; $display("FAIL steal: stolen=%b idx=%0d note0=%h expected 1 0 34", last_stolen, last_idx, voice_note[6:0]);
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h20);
        vectors++;
        if (voice_gate !== 4'b0001 || voice_velocity[6:0] !== 7'h20 || last_stolen !== 1'b0) begin
            errors++; $display("FAIL retrigger: gate=%b vel0=%h stolen=%b expected 0001 20 0", voice_gate, voice_velocity[6:0], last_stolen);
        end
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h00);
        vectors++;
        if (voice_gate !== 4'b0000 || last_upd !== 1'b1) begin
            errors++; $display("FAIL vel0_off: gate=%b upd=%b expected 0000 1", voice_gate, last_upd);
        end
    endtask

    task automatic test_filtering();
        do_reset();
        send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
        vectors++;
        if (voice_gate !== 4'b0000) begin
            errors++; $display("FAIL other_channel: gate=%b expected 0000", voice_gate);
        end
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
        vectors++;
        if (voice_gate !== 4'b0001 || voice_velocity[6:0] !== 7'h64) begin
            errors++; $display("FAIL realtime: gate=%b vel0=%h expected 0001 64", voice_gate, voice_velocity[6:0]);
        end
        send_byte(8'hB0); send_byte(8'h07); send_byte(8'h7F);
        send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
    endtask

    task automatic test_reset_mid_message();
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h3D);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (voice_gate !== '0 || voice_note !== '0 || midi_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset: gate=%b note=%h ready=%b expected 0 0 1", voice_gate, voice_note, midi_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        send_byte(8'h3D); send_byte(8'h64);
        send_byte(8'h90); send_byte(8'h40); send_byte(8'h64);
    endtask

    task automatic test_age_saturation();
        do_reset();
        send_byte(8'h90);
        for (int n = 'h50; n <= 'h53; n++) begin
            send_byte(8'(n)); send_byte(8'h40);
        end
        for (int k = 0; k < 61; k++) begin
            send_byte(8'('h51 + (k % 3))); send_byte(8'h40);
        end
        send_byte(8'h54); send_byte(8'h40);
        vectors++;
        if (last_stolen !== 1'b1 || last_idx !== 2'd0) begin
            errors++; $display("FAIL age_saturation: stolen=%b idx=%0d expected 1 0", last_stolen, last_idx);
        end
    endtask

    task automatic test_back_to_back();
        int e_upd, e_idx, e_st;
        bit ex;
        do_reset();
        send_byte(8'h90); send_byte(8'h45);
        midi_data = 8'h33; midi_valid = 1'b1;
        wait_accept(8'h33);
        ex = m_byte(8'h33);
        midi_data = 8'h46;
        vectors++;
        if (midi_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_exec_ready: got %b expected 0", midi_ready);
        end
        @(posedge clk); #1;
        if (ex) m_exec(e_upd, e_idx, e_st);
        vectors++;
        if (voice_update !== 1'b1 || voice_update_idx !== 2'd0 || midi_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first: upd=%b idx=%0d ready=%b expected 1 0 1", voice_update, voice_update_idx, midi_ready);
        end
        @(posedge clk); #1;
        ex = m_byte(8'h46);
        midi_data = 8'h22;
        @(posedge clk); #1;
        ex = m_byte(8'h22);
        midi_valid = 1'b0;
        @(posedge clk); #1;
        if (ex) m_exec(e_upd, e_idx, e_st);
        vectors++;
        if (voice_update !== 1'b1 || voice_update_idx !== 2'd1 || voice_note !== m_pack(1'b0) || voice_velocity !== m_pack(1'b1)) begin
            errors++; $display("FAIL b2b_second: upd=%b idx=%0d note=%h vel=%h expected 1 1 %h %h",
                               voice_update, voice_update_idx, voice_note, voice_velocity, m_pack(1'b0), m_pack(1'b1));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int r;
        logic [7:0] b;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       b = 8'h90 | 8'(CH);
            else if (r < 12) b = 8'h80 | 8'(CH);
            else if (r < 14) b = 8'h91;
            else if (r < 16) b = 8'hB0;
            else if (r < 18) b = 8'(8'hF8 + $urandom_range(0, 7));
            else if (r < 19) b = 8'hF2;
            else if (m_phase == 2) b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 127));
            else             b = 8'(8'h30 + $urandom_range(0, 5));
            send_byte(b);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        last_upd = 1'b0; last_idx = '0; last_stolen = 1'b0;
        test_reset();
        test_note_on();
        test_running_status();
        test_steal();
        test_retrigger();
        test_filtering();
        test_reset_mid_message();
        test_age_saturation();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
